// File: rtl/ysyx_22040759_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and requester IDs.
package ysyx_22040759_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/ysyx_22040759_arb_sel.sv
// Combinational winner selection between fetch and load/store requesters.
// YSYX_22040759_ARB_RR_EN selects round-robin; default is LSU priority with IF anti-starvation.
module ysyx_22040759_arb_sel
  import ysyx_22040759_pkg::*;
(
  input  logic if_valid,
  input  logic ls_valid,
  input  logic last_grant,
  input  logic burst_full,
  input  logic lock_valid,
  input  logic lock_id,
  output logic any_valid,
  output logic win_id
);

  logic lock_alive;

  // A stalled winner keeps the bus only while it still asserts valid.
  assign lock_alive = lock_valid && ((lock_id == REQ_LS) ? ls_valid : if_valid);

`ifdef YSYX_22040759_ARB_RR_EN
  logic unused_cfg;
  assign unused_cfg = burst_full;
`else
  logic unused_cfg;
  assign unused_cfg = last_grant;
`endif

  always_comb begin
    any_valid = if_valid | ls_valid;
    win_id    = REQ_IF;
    if (lock_alive) begin
      win_id = lock_id;
    end else if (if_valid && ls_valid) begin
`ifdef YSYX_22040759_ARB_RR_EN
      win_id = (last_grant == REQ_IF) ? REQ_LS : REQ_IF;
`else
      win_id = burst_full ? REQ_IF : REQ_LS;
`endif
    end else if (ls_valid) begin
      win_id = REQ_LS;
    end
  end

endmodule

// File: rtl/ysyx_22040759_mem_arb.sv
// Two-port (fetch, load/store) arbiter onto one memory port, one transaction outstanding.
// YSYX_22040759_ARB_RR_EN switches arbitration to round-robin.
module ysyx_22040759_mem_arb
  import ysyx_22040759_pkg::*;
#(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int LS_BURST_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_resp_valid,
  output logic [DW-1:0]   if_resp_data,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic            ls_req_wen,
  input  logic [AW-1:0]   ls_req_addr,
  input  logic [DW-1:0]   ls_req_wdata,
  input  logic [DW/8-1:0] ls_req_wmask,
  output logic            ls_resp_valid,
  output logic [DW-1:0]   ls_resp_data,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  arb_state_t    state;
  logic          last_grant;
  logic          lock_valid;
  logic          lock_id;
  logic          ls_store_q;
  logic          if_resp_valid_q;
  logic          ls_resp_valid_q;
  logic [DW-1:0] if_resp_data_q;
  logic [DW-1:0] ls_resp_data_q;
  logic          any_valid;
  logic          win_id;
  logic          burst_full;
  logic          sel_ls;
  logic          issue;
  logic          grant;

  ysyx_22040759_arb_sel u_arb_sel (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .last_grant (last_grant),
    .burst_full (burst_full),
    .lock_valid (lock_valid),
    .lock_id    (lock_id),
    .any_valid  (any_valid),
    .win_id     (win_id)
  );

  assign sel_ls = (win_id == REQ_LS);
  assign issue  = (state == IDLE) && any_valid && !rst;
  assign grant  = issue && mem_ready;

  assign mem_valid    = issue;
  assign mem_wen      = sel_ls & ls_req_wen;
  assign mem_addr     = sel_ls ? ls_req_addr : if_req_addr;
  assign mem_wdata    = sel_ls ? ls_req_wdata : '0;
  assign mem_wmask    = sel_ls ? ls_req_wmask : '0;
  assign if_req_ready = grant && !sel_ls;
  assign ls_req_ready = grant && sel_ls;

  // Responses are masked during reset so a pulse already in flight never escapes.
  assign if_resp_valid = if_resp_valid_q & ~rst;
  assign ls_resp_valid = ls_resp_valid_q & ~rst;
  assign if_resp_data  = rst ? '0 : if_resp_data_q;
  assign ls_resp_data  = rst ? '0 : ls_resp_data_q;

`ifdef YSYX_22040759_ARB_RR_EN
  assign burst_full = 1'b0;
`else
  localparam int CW = $clog2(LS_BURST_MAX + 1);
  logic [CW-1:0] ls_burst_cnt;

  assign burst_full = (ls_burst_cnt >= CW'(LS_BURST_MAX));

  // Consecutive LSU grants seen while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (rst || !if_req_valid) begin
      ls_burst_cnt <= '0;
    end else if (grant) begin
      if (!sel_ls) begin
        ls_burst_cnt <= '0;
      end else if (ls_burst_cnt < CW'(LS_BURST_MAX)) begin
        ls_burst_cnt <= ls_burst_cnt + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= REQ_IF;
      lock_valid      <= 1'b0;
      lock_id         <= REQ_IF;
      ls_store_q      <= 1'b0;
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      ls_resp_data_q  <= '0;
    end else begin
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            state      <= sel_ls ? WAIT_LS : WAIT_IF;
            last_grant <= win_id;
            lock_valid <= 1'b0;
            ls_store_q <= sel_ls & ls_req_wen;
          end else if (issue) begin
            lock_valid <= 1'b1;
            lock_id    <= win_id;
          end else begin
            lock_valid <= 1'b0;
          end
        end
        WAIT_IF: begin
          if (mem_rvalid) begin
            state           <= IDLE;
            if_resp_valid_q <= 1'b1;
            if_resp_data_q  <= mem_rdata;
          end
        end
        WAIT_LS: begin
          if (mem_rvalid) begin
            state           <= IDLE;
            ls_resp_valid_q <= 1'b1;
            ls_resp_data_q  <= ls_store_q ? '0 : mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_mem_arb.sv
// Directed bench for ysyx_22040759_mem_arb: vector table plus multi-cycle sequences.
module tb_ysyx_22040759_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_req_addr, if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_data;
  logic [7:0]  ls_req_wmask;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  ysyx_22040759_mem_arb #(.AW(64), .DW(64), .LS_BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wen(ls_req_wen),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        is_ls;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          stall;
    int          lat;
    logic [63:0] exp_data;
  } vec_t;

  vec_t        vecs[5];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_lat = 1;
  int          rsp_cnt = 0;
  logic [63:0] rsp_data;
  logic        exp_valid = 1'b0;
  logic        exp_is_ls = 1'b0;
  logic [63:0] exp_data;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_lat = -1;
  logic [63:0] last_data;
  logic        acc_seen, acc_was_ls;
  logic        glog[$];
  int          b2b = 0;
  int          if_pulses = 0;
  int          ls_pulses = 0;
  logic        exp_a[2];
  logic        exp_b[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rd_fn(input logic [63:0] a);
    return (a ^ 64'h8000_0000) + 64'h13;
  endfunction

  // One clock: sample handshakes before the edge, check responses and play memory after it.
  task automatic tick();
    logic        a_if, a_ls, a_wen, rsp_now;
    logic [63:0] a_addr;
    @(negedge clk);
    a_if    = if_req_ready;
    a_ls    = ls_req_ready;
    a_wen   = mem_wen;
    a_addr  = mem_addr;
    rsp_now = if_resp_valid | ls_resp_valid;
    chk("ready_onehot", {63'd0, a_if & a_ls}, 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    mem_rvalid = 1'b0;
    if (if_resp_valid || ls_resp_valid) begin
      if (if_resp_valid) if_pulses++;
      if (ls_resp_valid) ls_pulses++;
      chk("resp_expected", {63'd0, exp_valid}, 64'd1);
      chk("resp_port_ls", {63'd0, ls_resp_valid}, {63'd0, exp_is_ls});
      chk("resp_port_if", {63'd0, if_resp_valid}, {63'd0, ~exp_is_ls});
      last_data = ls_resp_valid ? ls_resp_data : if_resp_data;
      chk("resp_data", last_data, exp_data);
      last_lat  = cyc - acc_cyc;
      exp_valid = 1'b0;
    end
    if (a_if || a_ls) begin
      acc_seen   = 1'b1;
      acc_was_ls = a_ls;
      glog.push_back(a_ls);
      acc_cyc = cyc;
      if (rsp_now) b2b++;
      exp_valid = 1'b1;
      exp_is_ls = a_ls;
      exp_data  = (a_ls && ls_req_wen) ? 64'd0 : rd_fn(a_ls ? ls_req_addr : if_req_addr);
      rsp_cnt   = mem_lat;
      rsp_data  = a_wen ? 64'hffff_ffff_ffff_ffff : rd_fn(a_addr);
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rsp_data;
      end
    end
  endtask

  task automatic traffic(input int n_if, input int n_ls);
    int il, ll;
    il = n_if;
    ll = n_ls;
    for (int c = 0; c < 200 && (il > 0 || ll > 0 || exp_valid); c++) begin
      if_req_valid = (il > 0);
      ls_req_valid = (ll > 0);
      acc_seen = 1'b0;
      tick();
      if (acc_seen) begin
        if (acc_was_ls) ll--;
        else il--;
      end
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    chk("traffic_done", {63'd0, (il == 0 && ll == 0 && !exp_valid)}, 64'd1);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 64'h8000_0000, 64'h0,         8'h00, 0, 1, 64'h13};
    vecs[1] = '{1'b1, 1'b0, 64'h8000_0008, 64'h0,         8'h00, 0, 1, 64'h1b};
    vecs[2] = '{1'b1, 1'b1, 64'h8000_1000, 64'hdeadbeef,  8'h0f, 3, 1, 64'h0};
    vecs[3] = '{1'b0, 1'b0, 64'h8000_0100, 64'h0,         8'h00, 1, 3, 64'h113};
    vecs[4] = '{1'b1, 1'b0, 64'h8000_0040, 64'h0,         8'h00, 0, 2, 64'h53};
`ifdef YSYX_22040759_ARB_RR_EN
    exp_a[0] = 1'b0; exp_a[1] = 1'b1;
    exp_b[0] = 1'b0; exp_b[1] = 1'b1; exp_b[2] = 1'b0; exp_b[3] = 1'b1;
    exp_b[4] = 1'b1; exp_b[5] = 1'b1; exp_b[6] = 1'b1; exp_b[7] = 1'b1;
`else
    exp_a[0] = 1'b1; exp_a[1] = 1'b0;
    exp_b[0] = 1'b1; exp_b[1] = 1'b1; exp_b[2] = 1'b1; exp_b[3] = 1'b1;
    exp_b[4] = 1'b0; exp_b[5] = 1'b1; exp_b[6] = 1'b1; exp_b[7] = 1'b0;
`endif

    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_0008;
    ls_req_wdata = 64'd0; ls_req_wmask = 8'd0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    tick();
    tick();
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
    chk("rst_ls_ready", {63'd0, ls_req_ready}, 64'd0);
    chk("rst_if_resp", {63'd0, if_resp_valid}, 64'd0);
    chk("rst_ls_resp", {63'd0, ls_resp_valid}, 64'd0);
    chk("rst_if_data", if_resp_data, 64'd0);
    chk("rst_ls_data", ls_resp_data, 64'd0);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single transactions from the table.
    for (int i = 0; i < 5; i++) begin
      mem_lat = vecs[i].lat;
      if_pulses = 0;
      ls_pulses = 0;
      if_req_addr  = vecs[i].addr;
      ls_req_addr  = vecs[i].addr;
      ls_req_wen   = vecs[i].wen;
      ls_req_wdata = vecs[i].wdata;
      ls_req_wmask = vecs[i].wmask;
      if_req_valid = !vecs[i].is_ls;
      ls_req_valid = vecs[i].is_ls;
      acc_seen = 1'b0;
      for (int c = 0; c < 20 && !acc_seen; c++) begin
        mem_ready = (c >= vecs[i].stall);
        if (c < vecs[i].stall) begin
          #1;
          chk("stall_valid", {63'd0, mem_valid}, 64'd1);
          chk("stall_addr", mem_addr, vecs[i].addr);
          chk("stall_wen", {63'd0, mem_wen}, {63'd0, vecs[i].wen});
          chk("stall_ready", {63'd0, if_req_ready | ls_req_ready}, 64'd0);
          if (vecs[i].is_ls) begin
            chk("stall_wdata", mem_wdata, vecs[i].wdata);
            chk("stall_wmask", {56'd0, mem_wmask}, {56'd0, vecs[i].wmask});
          end
        end
        tick();
      end
      chk("vec_accepted", {63'd0, acc_seen}, 64'd1);
      chk("vec_accept_port", {63'd0, acc_was_ls}, {63'd0, vecs[i].is_ls});
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      for (int c = 0; c < 20 && exp_valid; c++) tick();
      chk("vec_resp_arrived", {63'd0, exp_valid}, 64'd0);
      chk("vec_latency", 64'(last_lat), 64'(vecs[i].lat));
      chk("vec_data", last_data, vecs[i].exp_data);
      tick();
      tick();
      chk("vec_if_pulses", 64'(if_pulses), {63'd0, ~vecs[i].is_ls});
      chk("vec_ls_pulses", 64'(ls_pulses), {63'd0, vecs[i].is_ls});
    end

    // Simultaneous requests.
    mem_ready = 1'b1;
    mem_lat = 1;
    if_req_addr = 64'h8000_0300;
    ls_req_addr = 64'h8000_0200;
    ls_req_wen = 1'b0;
    glog.delete();
    traffic(1, 1);
    chk("both_grants", 64'(glog.size()), 64'd2);
    for (int k = 0; k < 2 && k < glog.size(); k++)
      chk("both_order", {63'd0, glog[k]}, {63'd0, exp_a[k]});

    // Continuous LSU traffic against a waiting fetch.
    glog.delete();
    b2b = 0;
    traffic(2, 6);
    chk("burst_grants", 64'(glog.size()), 64'd8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      chk("burst_order", {63'd0, glog[k]}, {63'd0, exp_b[k]});
    chk("burst_back_to_back", 64'(b2b), 64'd7);

    // Reset while waiting on an LSU response, then a stale rvalid.
    mem_lat = 0;
    ls_req_addr = 64'h8000_0400;
    ls_req_valid = 1'b1;
    acc_seen = 1'b0;
    for (int c = 0; c < 10 && !acc_seen; c++) tick();
    chk("rstmid_accepted_ls", {63'd0, acc_seen & acc_was_ls}, 64'd1);
    ls_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    if_req_valid = 1'b1;
    #1;
    chk("rstmid_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rstmid_if_ready", {63'd0, if_req_ready}, 64'd0);
    tick();
    rst = 1'b0;
    if_req_valid = 1'b0;
    exp_valid = 1'b0;
    if_pulses = 0;
    ls_pulses = 0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'hbad;
    tick();
    tick();
    tick();
    chk("rstmid_no_resp", 64'(if_pulses + ls_pulses), 64'd0);
    if_req_addr = 64'h8000_0000;
    if_req_valid = 1'b1;
    #1;
    chk("rstmid_idle_issue", {63'd0, mem_valid}, 64'd1);
    mem_lat = 1;
    last_data = 64'd0;
    traffic(1, 0);
    chk("rstmid_if_data", last_data, 64'h13);

    // A stalled winner that withdraws is dropped in favour of the other requester.
    mem_ready = 1'b0;
    if_req_addr = 64'h8000_0500;
    ls_req_addr = 64'h8000_0600;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    tick();
    tick();
    chk("drop_locked_addr", mem_addr, 64'h8000_0600);
    ls_req_valid = 1'b0;
    #1;
    chk("drop_valid", {63'd0, mem_valid}, 64'd1);
    chk("drop_new_addr", mem_addr, 64'h8000_0500);
    mem_ready = 1'b1;
    glog.delete();
    traffic(1, 0);
    chk("drop_grants", 64'(glog.size()), 64'd1);
    chk("drop_if_data", last_data, 64'h513);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_mem_arb.md
YSYX_22040759_MEM_ARB -- requirements
Module: ysyx_22040759_mem_arb

Interface
REQ-001 SHALL have parameter AW, 64, request address width.
REQ-002 SHALL have parameter DW, 64, data width; the write mask is DW/8 bits.
REQ-003 SHALL have parameter LS_BURST_MAX, 4, maximum consecutive LSU grants while IF is pending (fixed-priority mode).
REQ-004 SHALL have ports:
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  if_req_valid  in  1  fetch request
  if_req_ready  out  1  fetch request accepted
  if_req_addr  in  AW  fetch address
  if_resp_valid  out  1  fetch data valid, 1-cycle pulse
  if_resp_data  out  DW  fetch data
  ls_req_valid  in  1  load/store request
  ls_req_ready  out  1  load/store request accepted
  ls_req_wen  in  1  1=store, 0=load
  ls_req_addr  in  AW  load/store address
  ls_req_wdata  in  DW  store data
  ls_req_wmask  in  DW/8  store byte mask
  ls_resp_valid  out  1  load data or store ack, 1-cycle pulse
  ls_resp_data  out  DW  load data; 0 for a store
  mem_valid  out  1  shared memory request
  mem_ready  in  1  memory accepts the request
  mem_wen  out  1  write
  mem_addr  out  AW  address
  mem_wdata  out  DW  write data
  mem_wmask  out  DW/8  byte mask
  mem_rvalid  in  1  memory response, read data or write ack
  mem_rdata  in  DW  read data

Function
REQ-005 SHALL implement FSM states IDLE, WAIT_IF and WAIT_LS, with exactly one transaction outstanding at a time.
REQ-006 In IDLE the block SHALL select a winner among valid requesters, drive mem_* combinationally from the winner's request, and assert mem_valid.
REQ-007 The winner's req_ready SHALL equal mem_ready in IDLE, the loser's req_ready SHALL be 0, and both SHALL be 0 outside IDLE.
REQ-008 On mem_valid&&mem_ready the FSM SHALL move to WAIT_IF or WAIT_LS according to the winner.
REQ-009 While mem_valid=1 and mem_ready=0, mem_* and the winner SHALL stay stable; the block SHALL NOT re-arbitrate.
REQ-010 In WAIT_x, on mem_rvalid the block SHALL register mem_rdata (LSU store: 0) and pulse x_resp_valid on the next cycle, then return to IDLE.
REQ-011 Latency from request acceptance to resp_valid SHALL be memory latency + 1 cycle; back-to-back issue SHALL be possible in the cycle resp_valid is high.
REQ-012 mem_rvalid SHALL be ignored in IDLE (stale response).
REQ-013 Fixed priority: LSU wins; a counter SHALL count consecutive LSU grants while if_req_valid=1.
REQ-014 When that counter reaches LS_BURST_MAX, IF SHALL win the next arbitration and the counter SHALL clear; the counter SHALL also clear on any IF grant or when if_req_valid=0.
REQ-015 A requester that drops valid before acceptance SHALL be removed from arbitration without error.

Reset
REQ-016 On rst the FSM SHALL enter IDLE, the counter SHALL clear, resp registers SHALL clear, and last-grant SHALL be set to IF.
REQ-017 Outputs under rst SHALL be: mem_valid=0, both req_ready=0, both resp_valid=0, resp data=0.
REQ-018 Reset mid-transaction SHALL abandon the outstanding request without a response pulse.

Configuration
REQ-019 With YSYX_22040759_ARB_RR_EN defined, arbitration SHALL be round-robin: when both requesters are valid, the winner is the one not granted last; the counter is unused.
REQ-020 Without YSYX_22040759_ARB_RR_EN, fixed-priority arbitration with the starvation counter (REQ-013, REQ-014) SHALL apply.

Structure
REQ-021 The FSM state encoding and the requester ID constants (REQ_IF=0, REQ_LS=1) SHALL live in the shared package ysyx_22040759_pkg.
REQ-022 Winner selection SHALL be one sub-module, ysyx_22040759_arb_sel, purely combinational; the FSM and response registers SHALL live in the top module.

Verification
REQ-023 IF only, addr 0x80000000, mem_ready=1, rvalid 1 cycle later with 0x13 -> if_resp_valid pulses with 0x13 two cycles after acceptance; ls_resp_valid stays 0.
REQ-024 Both valid simultaneously in fixed mode -> LSU granted first; IF granted after the LSU response; IF data correct.
REQ-025 LSU valid continuously and IF valid, LS_BURST_MAX=4 -> grant order LS,LS,LS,LS,IF,LS…; with RR_EN -> IF,LS,IF,LS.
REQ-026 Store addr 0x80001000, wdata 0xdeadbeef, wmask 0x0f, mem_ready low for 3 cycles -> mem_* held stable for all 3 cycles; ls_resp_valid with data 0 after the ack.
REQ-027 rst asserted in WAIT_LS, then mem_rvalid arrives -> no resp pulse; FSM stays in IDLE; the next IF request is served normally.
